// File: rtl/if_id_fetch_stage_pkg.sv
// Shared pipeline constants for the fetch stage and hazard control.
// Contents:
//   NOP_INSTR         - RV "addi x0,x0,0", inserted as the IF/ID bubble
//   DEFAULT_RESET_PC  - fetch address after reset
//   hazard enables    - polarity of PC_write / IF_ID_write from the hazard unit
//   fetch_ctrl_e      - per-cycle action of the fetch stage, in priority order
package if_id_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    // Hazard detection unit control encodings.
    localparam logic HZ_WRITE_EN   = 1'b1;
    localparam logic HZ_WRITE_HOLD = 1'b0;

    typedef enum logic [1:0] {
        CTRL_ADVANCE  = 2'd0,
        CTRL_STALL    = 2'd1,
        CTRL_REDIRECT = 2'd2,
        CTRL_RESET    = 2'd3
    } fetch_ctrl_e;

    // Resolve one cycle's action: reset > redirect > stall > advance.
    // CTRL_STALL covers either enable being held; the register update
    // still honours the two enables independently.
    function automatic fetch_ctrl_e fetch_ctrl(input logic reset,
                                               input logic branch_taken,
                                               input logic pc_write,
                                               input logic if_id_write);
        if (reset)
            return CTRL_RESET;
        if (branch_taken)
            return CTRL_REDIRECT;
        if (pc_write == HZ_WRITE_HOLD || if_id_write == HZ_WRITE_HOLD)
            return CTRL_STALL;
        return CTRL_ADVANCE;
    endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bus: hazard-unit controls, redirect, instruction memory
// read data, and the registered IF/ID and counter outputs.
// Modports:
//   master - drives controls/instr_rdata, observes the stage outputs
//   slave  - the fetch stage itself
interface if_id_fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            PC_write;
    logic            IF_ID_write;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic [31:0]     instr_rdata;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] IF_ID_pc;
    logic [31:0]     IF_ID_instr;
    logic            IF_ID_valid;
    logic [31:0]     stall_count;
    logic [31:0]     flush_count;

    modport master (
        output PC_write, IF_ID_write, branch_taken, branch_target, instr_rdata,
        input  pc, IF_ID_pc, IF_ID_instr, IF_ID_valid, stall_count, flush_count
    );

    modport slave (
        input  PC_write, IF_ID_write, branch_taken, branch_target, instr_rdata,
        output pc, IF_ID_pc, IF_ID_instr, IF_ID_valid, stall_count, flush_count
    );
endinterface

// File: rtl/if_id_fetch_stage_sat_counter.sv
// sat_counter: saturating up-counter, synchronous active-high reset.
// Ports:
//   clk     - clock
//   reset   - synchronous clear (wins over i_inc)
//   i_inc   - add one this cycle unless already at all-ones
//   o_count - registered count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + WIDTH'(1);
    end

    assign o_count = r_count;
endmodule

// File: rtl/if_id_fetch_stage.sv
// IF stage PC register plus IF/ID pipeline register with redirect flush,
// independent PC / IF-ID stall enables, and stall/flush event counters.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset
//   bus   - if_id_fetch_stage_if.slave (controls in, pc / IF/ID / counters out)
module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    if_id_fetch_stage_if.slave bus
);
    fetch_ctrl_e     w_ctrl;
    logic            w_stall_inc;
    logic            w_flush_inc;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_if_id_pc;
    logic [31:0]     r_if_id_instr;
    logic            r_if_id_valid;

    assign w_ctrl      = fetch_ctrl(reset, bus.branch_taken, bus.PC_write, bus.IF_ID_write);
    assign w_stall_inc = (w_ctrl == CTRL_STALL);
    assign w_flush_inc = (w_ctrl == CTRL_REDIRECT);

    always_ff @(posedge clk) begin
        case (w_ctrl)
            CTRL_RESET: begin
                r_pc          <= RESET_PC;
                r_if_id_pc    <= '0;
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
            end
            CTRL_REDIRECT: begin
                // Target is word-aligned here; the enables are ignored.
                r_pc          <= {bus.branch_target[XLEN-1:2], 2'b00};
                r_if_id_pc    <= r_pc;
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
            end
            default: begin
                if (bus.PC_write == HZ_WRITE_EN)
                    r_pc <= r_pc + XLEN'(4);
                if (bus.IF_ID_write == HZ_WRITE_EN) begin
                    r_if_id_pc    <= r_pc;
                    r_if_id_instr <= bus.instr_rdata;
                    r_if_id_valid <= 1'b1;
                end
            end
        endcase
    end

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall_inc),
        .o_count (bus.stall_count)
    );

    sat_counter #(.WIDTH(32)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_flush_inc),
        .o_count (bus.flush_count)
    );

    assign bus.pc          = r_pc;
    assign bus.IF_ID_pc    = r_if_id_pc;
    assign bus.IF_ID_instr = r_if_id_instr;
    assign bus.IF_ID_valid = r_if_id_valid;
endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I1  = 32'h00A0_0093;
    localparam logic [31:0] I2  = 32'h0010_0113;
    localparam logic [31:0] I3  = 32'h0020_0193;
    localparam logic [31:0] I4  = 32'h0030_0213;
    localparam logic [31:0] I5  = 32'h0040_0293;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_fetch_stage_if #(.XLEN(64)) bus ();

    if_id_fetch_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow instance of the counter so saturation is reachable quickly.
    logic       sat_rst;
    logic       sat_inc;
    logic [2:0] sat_cnt;
    sat_counter #(.WIDTH(3)) u_sat (
        .clk     (clk),
        .reset   (sat_rst),
        .i_inc   (sat_inc),
        .o_count (sat_cnt)
    );

    typedef struct {
        logic        rst;
        logic        pcw;
        logic        ifw;
        logic        bt;
        logic [63:0] tgt;
        logic [31:0] instr;
        logic [63:0] e_pc;
        logic [63:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_stall;
        logic [31:0] e_flush;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " pc"},          bus.pc,          v.e_pc);
        check({tag, " IF_ID_pc"},    bus.IF_ID_pc,    v.e_ifpc);
        check({tag, " IF_ID_instr"}, 64'(bus.IF_ID_instr), 64'(v.e_instr));
        check({tag, " IF_ID_valid"}, 64'(bus.IF_ID_valid), 64'(v.e_valid));
        check({tag, " stall_count"}, 64'(bus.stall_count), 64'(v.e_stall));
        check({tag, " flush_count"}, 64'(bus.flush_count), 64'(v.e_flush));
    endtask

    initial begin
        //           rst   pcw   ifw   bt    target        instr  e_pc        e_ifpc      e_instr e_v   e_st   e_fl
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0,        I1,    64'h0,      64'h0,      NOP,    1'b0, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        I1,    64'h4,      64'h0,      I1,     1'b1, 32'd0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        I2,    64'h8,      64'h4,      I2,     1'b1, 32'd0, 32'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        I3,    64'h8,      64'h4,      I2,     1'b1, 32'd1, 32'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,        I3,    64'h8,      64'h4,      I2,     1'b1, 32'd2, 32'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        I3,    64'hC,      64'h8,      I3,     1'b1, 32'd2, 32'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,        I4,    64'h10,     64'h8,      I3,     1'b1, 32'd3, 32'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0,        I4,    64'h10,     64'h10,     I4,     1'b1, 32'd4, 32'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h100,      I5,    64'h100,    64'h10,     NOP,    1'b0, 32'd4, 32'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        I5,    64'h104,    64'h100,    I5,     1'b1, 32'd4, 32'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h103,      I1,    64'h100,    64'h104,    NOP,    1'b0, 32'd4, 32'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, TOP,          I1,    TOP,        64'h100,    NOP,    1'b0, 32'd4, 32'd3};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        I1,    64'h0,      TOP,        I1,     1'b1, 32'd4, 32'd3};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h200,      I3,    64'h0,      64'h0,      NOP,    1'b0, 32'd0, 32'd0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,        I2,    64'h4,      64'h0,      I2,     1'b1, 32'd0, 32'd0};

        reset            = 1'b1;
        bus.PC_write     = 1'b1;
        bus.IF_ID_write  = 1'b1;
        bus.branch_taken = 1'b0;
        bus.branch_target = 64'h0;
        bus.instr_rdata  = 32'h0;
        sat_rst          = 1'b1;
        sat_inc          = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset             = vecs[i].rst;
            bus.PC_write      = vecs[i].pcw;
            bus.IF_ID_write   = vecs[i].ifw;
            bus.branch_taken  = vecs[i].bt;
            bus.branch_target = vecs[i].tgt;
            bus.instr_rdata   = vecs[i].instr;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Inputs changing between edges must not reach the outputs.
        @(negedge clk);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 64'h200;
        bus.instr_rdata   = I5;
        #2;
        check("comb pc",          bus.pc, 64'h4);
        check("comb IF_ID_valid", 64'(bus.IF_ID_valid), 64'h1);
        check("comb flush_count", 64'(bus.flush_count), 64'h0);
        @(posedge clk);
        #1;
        check("redir pc",          bus.pc, 64'h200);
        check("redir IF_ID_pc",    bus.IF_ID_pc, 64'h4);
        check("redir flush_count", 64'(bus.flush_count), 64'h1);
        check("redir stall_count", 64'(bus.stall_count), 64'h0);

        // Saturation on the narrow counter: max is 7.
        @(negedge clk);
        sat_rst = 1'b1;
        sat_inc = 1'b0;
        @(posedge clk);
        #1;
        check("sat reset", 64'(sat_cnt), 64'h0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            sat_rst = 1'b0;
            sat_inc = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("sat inc%0d", k), 64'(sat_cnt), 64'((k > 7) ? 7 : k));
        end
        @(negedge clk);
        sat_inc = 1'b0;
        @(posedge clk);
        #1;
        check("sat hold", 64'(sat_cnt), 64'h7);
        @(negedge clk);
        sat_rst = 1'b1;
        sat_inc = 1'b1;
        @(posedge clk);
        #1;
        check("sat reset wins", 64'(sat_cnt), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_id_fetch_stage.md
IF_ID_FETCH_STAGE -- requirements
Module: if_id_fetch_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath and PC width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port PC_write  input  1  1 = PC may advance; 0 = hold PC (load-use stall from the hazard detection unit).
REQ-006 Port IF_ID_write  input  1  1 = IF/ID register may load; 0 = hold IF/ID contents.
REQ-007 Port branch_taken  input  1  branch or jump resolved taken in a later stage.
REQ-008 Port branch_target  input  XLEN  redirect address, valid when branch_taken=1.
REQ-009 Port instr_rdata  input  32  instruction memory data for address pc, combinational read.
REQ-010 Port pc  output  XLEN  current fetch address, driven to instruction memory.
REQ-011 Port IF_ID_pc  output  XLEN  PC of the instruction held in IF/ID.
REQ-012 Port IF_ID_instr  output  32  instruction held in IF/ID.
REQ-013 Port IF_ID_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-014 Port stall_count  output  32  cycles in which the stage was stalled.
REQ-015 Port flush_count  output  32  cycles in which a redirect flushed IF/ID.

Function
REQ-016 Per-cycle priority SHALL be: reset > redirect (branch_taken=1) > stall > normal advance.
REQ-017 Normal advance (PC_write=1, IF_ID_write=1, branch_taken=0): pc <= pc+4; IF_ID_pc <= pc; IF_ID_instr <= instr_rdata; IF_ID_valid <= 1.
REQ-018 Redirect: pc <= branch_target; IF_ID_instr <= 32'h00000013 (NOP); IF_ID_valid <= 0; IF_ID_pc <= pc; PC_write and IF_ID_write are ignored that cycle.
REQ-019 Stall (branch_taken=0): PC_write=0 holds pc; IF_ID_write=0 holds IF_ID_pc, IF_ID_instr and IF_ID_valid; the two enables act independently.
REQ-020 PC_write=1 with IF_ID_write=0 SHALL advance pc and hold IF/ID; legal but the dropped instruction is the controller's responsibility.
REQ-021 pc+4 SHALL wrap modulo 2^XLEN; no overflow flag.
REQ-022 branch_target bits [1:0] SHALL be forced to 0 when loaded into pc.
REQ-023 stall_count SHALL increment by 1 in each non-reset cycle with branch_taken=0 and (PC_write=0 or IF_ID_write=0), saturating at 32'hFFFFFFFF.
REQ-024 flush_count SHALL increment by 1 in each non-reset cycle with branch_taken=1, saturating at 32'hFFFFFFFF.
REQ-025 All outputs SHALL be registered; a change on any input SHALL be visible on outputs one clock after sampling, never combinationally.

Reset
REQ-026 When reset=1 at a rising edge: pc <= RESET_PC; IF_ID_pc <= 0; IF_ID_instr <= 32'h00000013; IF_ID_valid <= 0; stall_count <= 0; flush_count <= 0.
REQ-027 Reset asserted mid-stall or coincident with branch_taken SHALL override both; the first cycle after reset deasserts fetches from RESET_PC.

Structure
REQ-028 The NOP encoding (32'h00000013) and RESET_PC default SHALL be constants in the shared pipeline package, alongside the hazard detection unit's control encodings.
REQ-029 One sub-module SHALL be instantiated twice: sat_counter (32-bit saturating counter with synchronous reset and increment enable) for stall_count and flush_count.

Verification
REQ-030 Reset then 3 normal cycles, instr_rdata=0x00A00093 -> pc=0,4,8,12; after cycle 1 IF_ID_pc=0, IF_ID_valid=1.
REQ-031 PC_write=0, IF_ID_write=0 for 2 cycles at pc=8 -> pc stays 8, IF/ID unchanged, stall_count increases by 2.
REQ-032 branch_taken=1, branch_target=0x100, with PC_write=0 same cycle -> next pc=0x100, IF_ID_instr=0x00000013, IF_ID_valid=0, flush_count+1, stall_count unchanged.
REQ-033 pc=0xFFFFFFFFFFFFFFFC, normal advance -> pc=0; branch_target=0x103 -> pc=0x100.
REQ-034 reset=1 coincident with branch_taken=1 during stall -> pc=RESET_PC, both counters 0, IF_ID_valid=0.
REQ-035 Preload counter to 32'hFFFFFFFE via forced stalls, stall 3 more cycles -> stall_count holds 32'hFFFFFFFF.
